// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the picoMIPS CPU: produces the execute enable
// that gates PC update and register write, plus a saturating executed-instruction count.
module cpu_run_ctrl #(
    parameter int Psize = 6,
    parameter int Cw    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [Psize-1:0] bp_addr,
    input  logic [Psize-1:0] pc_addr,
    input  logic             cnt_clr,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic             bp_hit,
    output logic [Cw-1:0]    instr_cnt
);

    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_STEP  = 2'b10;
    localparam logic [1:0] S_BREAK = 2'b11;

    logic [1:0]    state_q, state_d;
    logic          run_q, step_q;
    logic          skip_q, skip_d;
    logic          bp_hit_q, bp_hit_d;
    logic [Cw-1:0] cnt_q, cnt_d;

    logic run_rise, step_rise, bp_match;

    // run_req/step_req are request levels; only their rising edges (one cycle each)
    // are events, so a held level never issues more than one command.
    assign run_rise  = run_req & ~run_q;
    assign step_rise = step_req & ~step_q;
    // skip lets the instruction we just stopped on execute once after resuming.
    assign bp_match  = bp_en & (pc_addr == bp_addr) & ~skip_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_HALT;
            run_q    <= 1'b0;
            step_q   <= 1'b0;
            skip_q   <= 1'b0;
            bp_hit_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_req;
            step_q   <= step_req;
            skip_q   <= skip_d;
            bp_hit_q <= bp_hit_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (halt_req) begin
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_HALT, S_BREAK: begin
                    if (run_rise)       state_d = S_RUN;
                    else if (step_rise) state_d = S_STEP;
                end
                S_RUN:   if (bp_match) state_d = S_BREAK;
                S_STEP:  state_d = S_HALT;
                default: state_d = S_HALT;
            endcase
        end

        bp_hit_d = bp_hit_q;
        if (state_d == S_HALT)
            bp_hit_d = 1'b0;
        else if (state_q == S_BREAK && state_d != S_BREAK)
            bp_hit_d = 1'b0;
        else if (state_q == S_RUN && state_d == S_BREAK)
            bp_hit_d = 1'b1;

        skip_d = skip_q;
        if (state_d == S_RUN && state_q != S_RUN)
            skip_d = 1'b1;
        else if (cpu_en)
            skip_d = 1'b0;

        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (cpu_en && cnt_q != {Cw{1'b1}})
            cnt_d = cnt_q + {{(Cw-1){1'b0}}, 1'b1};
    end

    always_comb begin
        cpu_en    = ~halt_req & (((state_q == S_RUN) & ~bp_match) | (state_q == S_STEP));
        halted    = (state_q == S_HALT) | (state_q == S_BREAK);
        state     = state_q;
        bp_hit    = bp_hit_q;
        instr_cnt = cnt_q;
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random front-panel traffic, all
// checked against a cycle model that also plays the role of the program counter.
module tb_cpu_run_ctrl;

    localparam int PSIZE = 6;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_BREAK = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
    logic             bp_en = 1'b0;
    logic [PSIZE-1:0] bp_addr = '0, pc_addr = '0;
    logic             cnt_clr = 1'b0;
    logic             cpu_en, halted, bp_hit;
    logic [1:0]       state;
    logic [CW-1:0]    instr_cnt;

    int checks = 0;
    int failures = 0;

    // model of the controller and of the program counter it gates
    int m_mode, m_cnt, m_pc;
    bit m_prev_run, m_prev_step, m_skip, m_hit;
    bit last_en;

    cpu_run_ctrl #(.Psize(PSIZE), .Cw(CW)) dut (
        .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc_addr(pc_addr),
        .cnt_clr(cnt_clr), .cpu_en(cpu_en), .state(state), .halted(halted),
        .bp_hit(bp_hit), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_HALT; m_cnt = 0; m_pc = 0;
        m_prev_run = 0; m_prev_step = 0; m_skip = 0; m_hit = 0;
    endtask

    // One clock: drive at the falling edge, check mid-cycle, advance model after the rising edge.
    task automatic cycle(input bit run, input bit step, input bit halt, input bit clr);
        bit rr, sr, bpm, en, leave_break;
        int nmode;
        @(negedge clk);
        run_req = run; step_req = step; halt_req = halt; cnt_clr = clr;
        pc_addr = m_pc[PSIZE-1:0];
        #1;
        rr  = run && !m_prev_run;
        sr  = step && !m_prev_step;
        bpm = bp_en && (m_pc == int'(bp_addr)) && !m_skip;
        en  = !halt && ((m_mode == M_RUN && !bpm) || m_mode == M_STEP);
        check("cpu_en", cpu_en, en);
        check("state", state, m_mode);
        check("halted", halted, (m_mode == M_HALT || m_mode == M_BREAK));
        check("bp_hit", bp_hit, m_hit);
        check("instr_cnt", instr_cnt, m_cnt);
        last_en = cpu_en;

        nmode = m_mode;
        if (halt) nmode = M_HALT;
        else if (m_mode == M_HALT || m_mode == M_BREAK) nmode = rr ? M_RUN : (sr ? M_STEP : m_mode);
        else if (m_mode == M_RUN) nmode = bpm ? M_BREAK : M_RUN;
        else nmode = M_HALT;
        leave_break = (m_mode == M_BREAK && nmode != M_BREAK);

        @(posedge clk);
        #1;
        if (nmode == M_HALT || leave_break) m_hit = 0;
        else if (m_mode == M_RUN && nmode == M_BREAK) m_hit = 1;
        if (nmode == M_RUN && m_mode != M_RUN) m_skip = 1;
        else if (en) m_skip = 0;
        if (clr) m_cnt = 0;
        else if (en && m_cnt < CMAX) m_cnt = m_cnt + 1;
        if (en) m_pc = (m_pc + 1) % (1 << PSIZE);
        m_prev_run = run; m_prev_step = step; m_mode = nmode;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    // Assert reset between clock edges and check everything drops before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        run_req = 0; step_req = 0; halt_req = 0; cnt_clr = 0;
        reset = 1'b0;
        #1;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_state", state, 0);
        check("rst_halted", halted, 1);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_cnt", instr_cnt, 0);
        model_reset();
        @(negedge clk);
        pc_addr = '0;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check("por_cpu_en", cpu_en, 0);
        check("por_state", state, 0);
        check("por_halted", halted, 1);
        @(negedge clk);
        reset = 1'b1;

        // reset, then run for 10 enabled cycles
        cycle(1, 0, 0, 0);
        check("run_state", state, 1);
        idle(10);
        check("run_cnt10", instr_cnt, 10);

        // single step with step_req held for 5 cycles
        async_reset();
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        idle(2);
        check("step_cnt", instr_cnt, 1);
        check("step_state", state, 0);

        // breakpoint at 5, then resume through it
        async_reset();
        bp_en = 1; bp_addr = 6'd5;
        cycle(1, 0, 0, 0);
        idle(7);
        check("bp_state", state, 3);
        check("bp_hit", bp_hit, 1);
        check("bp_cnt", instr_cnt, 5);
        check("bp_pc", m_pc, 5);
        cycle(1, 0, 0, 0);
        check("resume_state", state, 1);
        check("resume_hit", bp_hit, 0);
        cycle(0, 0, 0, 0);
        check("resume_exec", last_en, 1);
        check("resume_pc", m_pc, 6);
        idle(3);
        bp_en = 0;

        // simultaneous edges with and without halt
        async_reset();
        cycle(1, 1, 1, 0);
        check("prio_halt_en", last_en, 0);
        check("prio_halt_state", state, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        check("prio_run_state", state, 1);
        idle(2);

        // halt mid-run drops cpu_en in the same cycle
        cycle(1, 0, 1, 0);
        check("halt_en", last_en, 0);
        check("halt_state", state, 0);

        // saturation, then clear while running
        async_reset();
        cycle(1, 0, 0, 0);
        idle(CMAX + 4);
        check("sat_cnt", instr_cnt, 16'hFFFF);
        cycle(0, 0, 0, 1);
        check("clr_cnt", instr_cnt, 0);
        cycle(0, 0, 0, 0);
        check("clr_inc", instr_cnt, 1);

        // async reset mid-run
        check("pre_rst_en", cpu_en, 1);
        async_reset();

        // random front-panel traffic
        bp_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) bp_addr = PSIZE'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) bp_en = ~bp_en;
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
        end
        async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
